// File: rtl/instr_fetch_queue.sv
// instr_fetch_queue: instruction fetch front-end.
// Owns the program counter and issues one word read per cycle to an instruction memory with a
// fixed one-cycle read latency. Returned words are buffered with their PCs in a DEPTH-entry
// FIFO, and the core pops them with a valid/ready handshake. A redirect flushes all buffered
// and in-flight words and restarts fetch at the new PC.
//
// Ports:
//   clock, reset_n             clock (rising edge), synchronous active-low reset
//   imem_req, imem_addr        read strobe and word-aligned address to instruction memory
//   imem_rdata                 read data, valid the cycle after imem_req
//   redirect_valid/_pc         one-cycle flush-and-restart pulse with target PC
//   instr_valid/_ready         head-entry handshake with the core
//   instr_out, instr_pc        head instruction word and its PC (zero when empty)
//   queue_count                occupied FIFO entries
//   perf_fetched, perf_stall   optional performance counters (FETCHQ_PERF_CNT_EN)
//
// Optional feature macro: FETCHQ_PERF_CNT_EN adds the two performance counter outputs.
module instr_fetch_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                         clock,
  input  logic                         reset_n,
  output logic                         imem_req,
  output logic [31:0]                  imem_addr,
  input  logic [31:0]                  imem_rdata,
  input  logic                         redirect_valid,
  input  logic [31:0]                  redirect_pc,
  output logic                         instr_valid,
  input  logic                         instr_ready,
  output logic [31:0]                  instr_out,
  output logic [31:0]                  instr_pc,
  output logic [$clog2(DEPTH+1)-1:0]   queue_count
`ifdef FETCHQ_PERF_CNT_EN
  ,
  output logic [31:0]                  perf_fetched,
  output logic [31:0]                  perf_stall
`endif
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = $clog2(DEPTH + 1);
  localparam logic [CntW:0] DepthOcc = DEPTH[CntW:0];

  logic [31:0]     pcQ;
  logic            inflightQ;
  logic [31:0]     inflightPcQ;
  logic [31:0]     memWord [DEPTH];
  logic [31:0]     memPc   [DEPTH];
  logic [PtrW-1:0] wrPtrQ;
  logic [PtrW-1:0] rdPtrQ;
  logic [CntW-1:0] countQ;
  logic [CntW:0]   occupancy;
  logic            push;
  logic            pop;
  logic            unusedRedirectLsbs;

  assign unusedRedirectLsbs = ^redirect_pc[1:0];

  // Reserve a slot for the in-flight word so a response never lands in a full FIFO.
  assign occupancy = {1'b0, countQ} + {{CntW{1'b0}}, inflightQ};
  assign imem_req  = reset_n & ~redirect_valid & (occupancy < DepthOcc);
  assign imem_addr = pcQ;

  // Responses and pops arriving in a redirect cycle are discarded.
  assign push = inflightQ & ~redirect_valid;
  assign pop  = instr_valid & instr_ready & ~redirect_valid;

  assign instr_valid = (countQ != '0);
  assign instr_out   = instr_valid ? memWord[rdPtrQ] : 32'h0;
  assign instr_pc    = instr_valid ? memPc[rdPtrQ]   : 32'h0;
  assign queue_count = countQ;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      pcQ         <= RESET_PC;
      inflightQ   <= 1'b0;
      inflightPcQ <= 32'h0;
      wrPtrQ      <= '0;
      rdPtrQ      <= '0;
      countQ      <= '0;
    end else if (redirect_valid) begin
      pcQ       <= {redirect_pc[31:2], 2'b00};
      inflightQ <= 1'b0;
      wrPtrQ    <= '0;
      rdPtrQ    <= '0;
      countQ    <= '0;
    end else begin
      inflightQ <= imem_req;
      if (imem_req) begin
        pcQ         <= pcQ + 32'd4;
        inflightPcQ <= pcQ;
      end
      if (push) wrPtrQ <= wrPtrQ + 1'b1;
      if (pop)  rdPtrQ <= rdPtrQ + 1'b1;
      case ({push, pop})
        2'b10:   countQ <= countQ + 1'b1;
        2'b01:   countQ <= countQ - 1'b1;
        default: countQ <= countQ;
      endcase
    end
  end

  // Storage needs no reset: outputs are masked while the FIFO is empty.
  always_ff @(posedge clock) begin
    if (reset_n && push) begin
      memWord[wrPtrQ] <= imem_rdata;
      memPc[wrPtrQ]   <= inflightPcQ;
    end
  end

`ifdef FETCHQ_PERF_CNT_EN
  logic [31:0] perfFetchedQ;
  logic [31:0] perfStallQ;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      perfFetchedQ <= 32'h0;
      perfStallQ   <= 32'h0;
    end else begin
      if (pop)          perfFetchedQ <= perfFetchedQ + 32'd1;
      if (!instr_valid) perfStallQ   <= perfStallQ + 32'd1;
    end
  end

  assign perf_fetched = perfFetchedQ;
  assign perf_stall   = perfStallQ;
`endif

endmodule
